// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: note half-periods, octave codes
// and FSM state encoding.
package tone_pkg;

  localparam int CNT_W      = 18;
  localparam int REF_CLK_HZ = 50_000_000;

  localparam logic [1:0] OCT_BASE  = 2'd0;
  localparam logic [1:0] OCT_UP1   = 2'd1;
  localparam logic [1:0] OCT_UP2   = 2'd2;
  localparam logic [1:0] OCT_DOWN1 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Half-periods in REF_CLK_HZ cycles for C4..B4; key 0 is silence.
  function automatic int unsigned base_half(input logic [2:0] key);
    case (key)
      3'd1:    base_half = 95556;
      3'd2:    base_half = 85131;
      3'd3:    base_half = 75843;
      3'd4:    base_half = 71586;
      3'd5:    base_half = 63776;
      3'd6:    base_half = 56818;
      3'd7:    base_half = 50619;
      default: base_half = 0;
    endcase
  endfunction

endpackage

// File: rtl/tone_period_rom.sv
// Combinational key + octave to half-period lookup, with the base table
// rescaled at elaboration time to the actual clock frequency.
module tone_period_rom #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int CNT_W       = 18
) (
  input  logic [2:0]       key_id,
  input  logic [1:0]       octave,
  output logic [CNT_W-1:0] half_period
);
  import tone_pkg::*;

  logic [CNT_W-1:0] base_tab [8];
  logic [CNT_W-1:0] base_sel;

  for (genvar gi = 0; gi < 8; gi++) begin : g_tab
    localparam longint unsigned SCALED =
      (longint'(base_half(3'(gi))) * longint'(CLK_FREQ_HZ)) / longint'(REF_CLK_HZ);
    assign base_tab[gi] = CNT_W'(SCALED);
  end

  always_comb begin
    base_sel = base_tab[key_id];
    case (octave)
      OCT_UP1:   half_period = base_sel >> 1;
      OCT_UP2:   half_period = base_sel >> 2;
      OCT_DOWN1: half_period = base_sel << 1;
      default:   half_period = base_sel;
    endcase
  end

endmodule

// File: rtl/tone_generator.sv
// Key-driven square-wave buzzer: IDLE/PLAY/RELEASE FSM with a half-period
// counter and pitch changes deferred to the next toggle edge.
module tone_generator #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int CNT_W       = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] active_key_id,
  input  logic       key_is_pressed,
  input  logic [1:0] octave_sel,
  output logic       buzzer_out,
  output logic       note_playing,
  output logic [2:0] current_key_id
);
  import tone_pkg::*;

  state_t           state_reg, state_next;
  logic [2:0]       key_reg;
  logic             pressed_reg;
  logic [1:0]       oct_reg;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             buzzer_reg, buzzer_next;
  logic             note_playing_reg;
  logic [2:0]       cur_key_reg, cur_key_next;
  logic [1:0]       cur_oct_reg, cur_oct_next;
  logic             pending_reg, pending_next;
  logic [2:0]       pending_key_reg, pending_key_next;
  logic [1:0]       pending_oct_reg, pending_oct_next;

  logic             valid;
  logic             terminal;
  logic [2:0]       rom_key;
  logic [1:0]       rom_oct;
  logic [CNT_W-1:0] rom_period;

  assign valid    = pressed_reg && (key_reg != 3'd0);
  assign terminal = (counter_reg == period_reg - CNT_W'(1));
  // A fresh press looks up the sampled key; otherwise only the pending pitch matters.
  assign rom_key  = (state_reg == ST_IDLE) ? key_reg : pending_key_reg;
  assign rom_oct  = (state_reg == ST_IDLE) ? oct_reg : pending_oct_reg;

  tone_period_rom #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .CNT_W      (CNT_W)
  ) u_rom (
    .key_id     (rom_key),
    .octave     (rom_oct),
    .half_period(rom_period)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      key_reg          <= 3'd0;
      pressed_reg      <= 1'b0;
      oct_reg          <= 2'd0;
      counter_reg      <= '0;
      period_reg       <= '0;
      buzzer_reg       <= 1'b0;
      note_playing_reg <= 1'b0;
      cur_key_reg      <= 3'd0;
      cur_oct_reg      <= 2'd0;
      pending_reg      <= 1'b0;
      pending_key_reg  <= 3'd0;
      pending_oct_reg  <= 2'd0;
    end else begin
      state_reg        <= state_next;
      key_reg          <= active_key_id;
      pressed_reg      <= key_is_pressed;
      oct_reg          <= octave_sel;
      counter_reg      <= counter_next;
      period_reg       <= period_next;
      buzzer_reg       <= buzzer_next;
      note_playing_reg <= (state_next != ST_IDLE);
      cur_key_reg      <= cur_key_next;
      cur_oct_reg      <= cur_oct_next;
      pending_reg      <= pending_next;
      pending_key_reg  <= pending_key_next;
      pending_oct_reg  <= pending_oct_next;
    end
  end

  // Terminal count is resolved before release: a toggle that lands low ends the note.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (valid) state_next = ST_PLAY;
      ST_PLAY, ST_RELEASE: begin
        if (valid)                       state_next = ST_PLAY;
        else if (terminal && buzzer_reg) state_next = ST_IDLE;
        else                             state_next = ST_RELEASE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    counter_next     = counter_reg;
    period_next      = period_reg;
    buzzer_next      = buzzer_reg;
    cur_key_next     = cur_key_reg;
    cur_oct_next     = cur_oct_reg;
    pending_next     = pending_reg;
    pending_key_next = pending_key_reg;
    pending_oct_next = pending_oct_reg;
    if (state_reg == ST_IDLE) begin
      counter_next = '0;
      buzzer_next  = 1'b0;
      pending_next = 1'b0;
      if (valid) begin
        period_next      = rom_period;
        cur_key_next     = key_reg;
        cur_oct_next     = oct_reg;
        buzzer_next      = 1'b1;
        pending_key_next = key_reg;
        pending_oct_next = oct_reg;
      end
    end else begin
      counter_next = terminal ? '0 : counter_reg + CNT_W'(1);
      if (terminal) begin
        buzzer_next = ~buzzer_reg;
        if (state_reg == ST_PLAY && pending_reg) begin
          period_next  = rom_period;
          cur_key_next = pending_key_reg;
          cur_oct_next = pending_oct_reg;
        end
      end
      // Pending always tracks the latest sample; it is live only if it differs.
      if (valid) begin
        pending_key_next = key_reg;
        pending_oct_next = oct_reg;
        pending_next     = (key_reg != cur_key_next) || (oct_reg != cur_oct_next);
      end else begin
        pending_next = 1'b0;
      end
      if (state_next == ST_IDLE) begin
        cur_key_next = 3'd0;
        counter_next = '0;
      end
    end
  end

  assign buzzer_out     = buzzer_reg;
  assign note_playing   = note_playing_reg;
  assign current_key_id = cur_key_reg;

endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator: a note-timeline model checked every
// cycle, plus literal pitch and timing expectations.
module tb_tone_generator;

  localparam int CLK_HZ = 50000;  // scales every half-period by 1/1000

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] active_key_id = 3'd0;
  logic       key_is_pressed = 1'b0;
  logic [1:0] octave_sel = 2'd0;
  logic       buzzer_out;
  logic       note_playing;
  logic [2:0] current_key_id;
  logic [2:0] rk = 3'd0;
  logic [1:0] ro = 2'd0;
  logic [17:0] rp;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tone_generator #(.CLK_FREQ_HZ(CLK_HZ), .CNT_W(18)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .active_key_id (active_key_id),
    .key_is_pressed(key_is_pressed),
    .octave_sel    (octave_sel),
    .buzzer_out    (buzzer_out),
    .note_playing  (note_playing),
    .current_key_id(current_key_id)
  );

  tone_period_rom u_rom_ref (
    .key_id     (rk),
    .octave     (ro),
    .half_period(rp)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Half-period in cycles: base note scaled to the clock, then octave shift.
  function automatic int half(input int key, input int oct, input longint hz);
    longint b;
    case (key)
      1: b = 95556; 2: b = 85131; 3: b = 75843; 4: b = 71586;
      5: b = 63776; 6: b = 56818; 7: b = 50619; default: b = 0;
    endcase
    b = b * hz / 50000000;
    case (oct)
      1: b = b / 2;
      2: b = b / 4;
      3: b = b * 2;
      default: ;
    endcase
    return int'(b);
  endfunction

  // Note timeline: mode 0 silent, 1 held, 2 releasing; 'left' counts down the half-period.
  typedef struct packed {
    int mode; int level; int left; int len; int key; int oct;
    int pv; int pk; int po; int sk; int sp; int so;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t c, input int k, input int p, input int o);
    model_t n;
    bit valid;
    bit tog;
    n = c;
    valid = (c.sp != 0) && (c.sk != 0);
    if (c.mode == 0) begin
      n.pv = 0;
      if (valid) begin
        n.mode = 1; n.level = 1; n.len = half(c.sk, c.so, CLK_HZ);
        n.left = n.len; n.key = c.sk; n.oct = c.so;
      end
    end else begin
      n.left = c.left - 1;
      tog = (n.left == 0);
      if (tog) begin
        n.level = 1 - c.level;
        if (c.mode == 1 && c.pv != 0) begin
          n.len = half(c.pk, c.po, CLK_HZ); n.key = c.pk; n.oct = c.po;
        end
        n.left = n.len;
      end
      if (valid) begin
        n.pv = ((c.sk != n.key) || (c.so != n.oct)) ? 1 : 0;
        n.pk = c.sk; n.po = c.so; n.mode = 1;
      end else begin
        n.pv = 0;
        if (tog && n.level == 0) begin n.mode = 0; n.key = 0; end
        else n.mode = 2;
      end
    end
    n.sk = k; n.sp = p; n.so = o;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, int'(active_key_id), int'(key_is_pressed), int'(octave_sel));
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("buzzer_out", 32'(buzzer_out), 32'(m.level));
      check("note_playing", 32'(note_playing), (m.mode != 0) ? 32'd1 : 32'd0);
      check("current_key_id", 32'(current_key_id), (m.mode != 0) ? 32'(m.key) : 32'd0);
    end
  end

  task automatic drive(input int k, input int p, input int o);
    active_key_id  = 3'(k);
    key_is_pressed = p[0];
    octave_sel     = 2'(o);
  endtask

  // Count falling clock edges until buzzer_out reaches val; bounded.
  task automatic cycles_until(input logic val, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (buzzer_out !== val && n < 2000);
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL timeout: buzzer_out never reached %0d within %0d cycles", val, n);
    end
  endtask

  initial begin
    int n;
    // Table pinned by hand at the 50 MHz reference, and the model against the ROM.
    rk = 3'd6; ro = 2'd0; #1 check("rom_k6_o0", 32'(rp), 32'd56818);
    rk = 3'd1; ro = 2'd3; #1 check("rom_k1_o3", 32'(rp), 32'd191112);
    rk = 3'd1; ro = 2'd2; #1 check("rom_k1_o2", 32'(rp), 32'd23889);
    rk = 3'd7; ro = 2'd0; #1 check("rom_k7_o0", 32'(rp), 32'd50619);
    rk = 3'd3; ro = 2'd0; #1 check("rom_k3_o0", 32'(rp), 32'd75843);
    for (int k = 0; k < 8; k++) begin
      for (int o = 0; o < 4; o++) begin
        rk = 3'(k); ro = 2'(o);
        #1 check("rom_vs_model", 32'(rp), 32'(half(k, o, 50000000)));
      end
    end

    rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_buzzer", 32'(buzzer_out), 32'd0);
    check("reset_key", 32'(current_key_id), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Key 6, base octave: 2-edge latency, 56-cycle half-periods.
    drive(6, 1, 0);
    cycles_until(1'b1, n); check("latency_k6", 32'(n), 32'd2);
    check("key_k6", 32'(current_key_id), 32'd6);
    cycles_until(1'b0, n); check("half_k6_high", 32'(n), 32'd56);
    cycles_until(1'b1, n); check("half_k6_low", 32'(n), 32'd56);

    // Key 1 an octave down, then two up.
    drive(1, 1, 3);
    cycles_until(1'b0, n); check("k6_completes", 32'(n), 32'd56);
    cycles_until(1'b1, n); check("half_k1_o3", 32'(n), 32'd190);
    drive(1, 1, 2);
    cycles_until(1'b0, n); check("k1_o3_completes", 32'(n), 32'd190);
    cycles_until(1'b1, n); check("half_k1_o2", 32'(n), 32'd23);

    // Key 1 to key 7 in the middle of a half-period.
    drive(1, 1, 0);
    cycles_until(1'b0, n); check("k1_o2_completes", 32'(n), 32'd23);
    cycles_until(1'b1, n); check("half_k1", 32'(n), 32'd95);
    repeat (20) @(negedge clk);
    drive(7, 1, 0);
    cycles_until(1'b0, n); check("k1_not_truncated", 32'(n + 20), 32'd95);
    cycles_until(1'b1, n); check("half_k7", 32'(n), 32'd50);

    // Release while high: falls at the end of the half, then silent.
    repeat (10) @(negedge clk);
    drive(0, 0, 0);
    cycles_until(1'b0, n); check("release_fall", 32'(n + 10), 32'd50);
    check("release_np", 32'(note_playing), 32'd0);
    check("release_key", 32'(current_key_id), 32'd0);

    // Re-press key 3 during release: no gap, new pitch from the next toggle.
    drive(5, 1, 0);
    cycles_until(1'b1, n); check("latency_k5", 32'(n), 32'd2);
    drive(0, 0, 0);
    repeat (5) @(negedge clk);
    drive(3, 1, 0);
    cycles_until(1'b0, n); check("k5_completes", 32'(n + 5), 32'd63);
    check("repress_np", 32'(note_playing), 32'd1);
    check("repress_key", 32'(current_key_id), 32'd3);
    cycles_until(1'b1, n); check("half_k3", 32'(n), 32'd75);

    // Pressed flag with key ID 0 is not a press.
    drive(0, 0, 0);
    repeat (200) @(negedge clk);
    drive(0, 1, 2);
    repeat (100) @(negedge clk);
    check("id0_silent", 32'(buzzer_out), 32'd0);

    // Randomised holds, changes, releases and octave swaps.
    for (int s = 0; s < 300; s++) begin
      drive(int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 150)) @(negedge clk);
    end

    // Asynchronous reset mid-note silences at once; replay needs a fresh sample.
    drive(0, 0, 0);
    repeat (250) @(negedge clk);
    drive(2, 1, 0);
    cycles_until(1'b1, n);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_buzzer", 32'(buzzer_out), 32'd0);
    check("async_rst_np", 32'(note_playing), 32'd0);
    check("async_rst_key", 32'(current_key_id), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycles_until(1'b1, n); check("post_reset_latency", 32'(n), 32'd2);
    cycles_until(1'b0, n); check("half_k2", 32'(n), 32'd85);
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tone_generator.md
TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, system clock frequency used to derive note half-periods.
REQ-002 SHALL have parameter CNT_W, default 18, width of the half-period counter and period registers.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port active_key_id, input, 3, debounced key ID: 0 means none, 1-7 means Key1-Key7 (C4..B4).
REQ-006 SHALL have port key_is_pressed, input, 1, high while any debounced key is held.
REQ-007 SHALL have port octave_sel, input, 2, octave shift: 0 = base, 1 = up one, 2 = up two, 3 = down one.
REQ-008 SHALL have port buzzer_out, output, 1, registered square wave driving the buzzer.
REQ-009 SHALL have port note_playing, output, 1, high in states PLAY and RELEASE.
REQ-010 SHALL have port current_key_id, output, 3, key ID whose pitch is currently sounding; 0 when idle.

Function
REQ-011 SHALL register active_key_id, key_is_pressed and octave_sel once on entry; the FSM uses only the registered copies.
REQ-012 SHALL treat key_is_pressed=1 with active_key_id=0 as not pressed.
REQ-013 SHALL map base half-periods (cycles at 50 MHz) as: 1=95556, 2=85131, 3=75843, 4=71586, 5=63776, 6=56818, 7=50619.
REQ-014 SHALL derive the effective half-period as base>>1 for octave 1, base>>2 for octave 2, and base<<1 for octave 3, all kept in CNT_W bits with no overflow (max 191112).
REQ-015 SHALL implement FSM states IDLE, PLAY and RELEASE.
REQ-016 IDLE: buzzer_out=0, counter=0; a valid press loads period_reg and current_key_id, sets buzzer_out=1 on the next edge, and moves to PLAY.
REQ-017 Latency: a press presented before edge k SHALL produce buzzer_out=1 after edge k+1.
REQ-018 PLAY: the counter SHALL count 0..period_reg-1; at the terminal count it SHALL toggle buzzer_out and reload 0.
REQ-019 A key-ID or octave change while pressed SHALL be latched as pending and applied to period_reg and current_key_id only at the next toggle, so no half-cycle is truncated.
REQ-020 Multiple changes within one half-period SHALL apply only the last value.
REQ-021 A release in PLAY SHALL move to RELEASE; a release with buzzer_out=0 at a terminal count SHALL go directly to IDLE.
REQ-022 RELEASE: toggling SHALL continue at period_reg until the toggle that drives buzzer_out to 0, then the FSM SHALL enter IDLE and clear current_key_id.
REQ-023 A new valid press during RELEASE SHALL return the FSM to PLAY, with the new period pending until the next toggle.
REQ-024 Simultaneous release and terminal count SHALL be resolved as the terminal count first, then the release.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst_n=0, all registers SHALL clear immediately: state=IDLE, buzzer_out=0, note_playing=0, current_key_id=0, counter=0, period_reg=0, pending=0.
REQ-027 Reset mid-note SHALL silence the output at once; after release from reset, the first tone SHALL need a fresh press sample.

Structure
REQ-028 SHALL place the base half-period constants, the FSM state encoding, CNT_W and the octave codes in a shared package tone_pkg.
REQ-029 SHALL implement the key-plus-octave to half-period mapping in a combinational sub-module tone_period_rom; the FSM, counter and pending logic SHALL remain in tone_generator.

Verification
REQ-030 Press key 6 with octave 0 and hold -> buzzer high after 2 edges, then toggles every 56818 cycles (period 113636); current_key_id=6.
REQ-031 Key 1 with octave 3 -> half-period 191112; the counter SHALL not overflow; with octave 2 -> half-period 23889.
REQ-032 Switch key 1 to key 7 mid-half-period -> the current half-period completes at 95556 cycles, then subsequent half-periods are 50619 cycles.
REQ-033 Release while buzzer_out=1 -> output falls at the end of the current half-period, then IDLE with note_playing=0 and current_key_id=0.
REQ-034 Release then re-press key 3 during RELEASE -> returns to PLAY with no forced low gap; new half-period 75843 from the next toggle.
REQ-035 key_is_pressed=1 with ID 0 -> output stays 0; rst_n asserted mid-note -> buzzer_out=0 in the same cycle and all outputs at reset values.
